vscpu_mem_hs: RTL and testbench

- Parametrised successor to the team's very-simple CPU: same 4-bit-opcode, two-address memory-to-memory ISA.
- Address and data widths are generics.
- Memory is reached over a variable-latency req/rdy handshake instead of a fixed one-cycle RAM.
- Adds run gating, self-loop halt detection and a retired-instruction counter. Sits between the program/data RAM (or bus bridge) and the test harness.

---
 rtl/vscpu_mem_hs.sv | 253 +++++++++++++++++++++++++
 tb/tb_vscpu_mem_hs.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscpu_mem_hs.sv
// vscpu_mem_hs: very-simple CPU with a variable-latency memory handshake.
// The ISA is memory-to-memory. Each instruction word holds a 4-bit opcode and
// two ADDR_W-bit operand fields, A and B. Every memory access is a req/rdy
// transaction. Request, write enable, address and write data are registered,
// and they stay stable until mem_rdy completes the transaction.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   run        fetch enable, sampled only in IDLE before a new fetch
//   mem_req    memory transaction request
//   mem_we     1=write, 0=read (valid while mem_req)
//   mem_addr   transaction address
//   mem_wdata  write data
//   mem_rdata  read data, valid in the cycle mem_rdy=1
//   mem_rdy    transaction completes at the posedge where mem_req&mem_rdy
//   halted     CPU stopped on a self-loop branch
//   pc         current program counter
//   retired    completed-instruction count (wraps)
module vscpu_mem_hs #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int RET_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [RET_W-1:0]  retired
);

  localparam int IW_W = 4 + 2*ADDR_W;

  if (DATA_W < IW_W) begin : g_width_check
    $error("vscpu_mem_hs: DATA_W must be >= 4+2*ADDR_W");
  end

  // Opcode groups: op[3:1]. op[0] selects the immediate form.
  localparam logic [2:0] G_ADD  = 3'd0;
  localparam logic [2:0] G_NAND = 3'd1;
  localparam logic [2:0] G_SRL  = 3'd2;
  localparam logic [2:0] G_LT   = 3'd3;
  localparam logic [2:0] G_CP   = 3'd4;
  localparam logic [2:0] G_CPI  = 3'd5;
  localparam logic [2:0] G_BZJ  = 3'd6;
  localparam logic [2:0] G_MUL  = 3'd7;

  localparam logic [DATA_W-1:0] W_DW    = DATA_W'(DATA_W);
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
  localparam logic [RET_W-1:0]  RET_ONE = RET_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RDB, S_RDA, S_RDI, S_WR, S_HALT
  } state_t;

  state_t            r_state;
  logic [IW_W-1:0]   r_iw;
  logic [DATA_W-1:0] r_rb;
  logic [ADDR_W-1:0] r_ra;

  // Decode of the word arriving in FETCH (not yet latched)
  logic [2:0]        w_f_grp;
  logic              w_f_imm;
  logic [ADDR_W-1:0] w_f_a;
  logic [ADDR_W-1:0] w_f_b;
  // Decode of the latched instruction word
  logic [2:0]        w_grp;
  logic              w_imm;
  logic [ADDR_W-1:0] w_a;
  logic [ADDR_W-1:0] w_b;
  logic [DATA_W-1:0] w_b_ext;
  logic [DATA_W-1:0] w_opb;
  logic [DATA_W-1:0] w_shift2;
  logic [DATA_W-1:0] w_alu;
  logic [ADDR_W-1:0] w_tgt;

  assign w_f_grp = mem_rdata[IW_W-1:2*ADDR_W+1];
  assign w_f_imm = mem_rdata[2*ADDR_W];
  assign w_f_a   = mem_rdata[2*ADDR_W-1:ADDR_W];
  assign w_f_b   = mem_rdata[ADDR_W-1:0];

  assign w_grp   = r_iw[IW_W-1:2*ADDR_W+1];
  assign w_imm   = r_iw[2*ADDR_W];
  assign w_a     = r_iw[2*ADDR_W-1:ADDR_W];
  assign w_b     = r_iw[ADDR_W-1:0];
  assign w_b_ext = {{(DATA_W-ADDR_W){1'b0}}, w_b};
  assign w_opb   = w_imm ? w_b_ext : r_rb;

  // ALU. Operand A is taken straight from mem_rdata during the RDA read, so
  // the result is ready on the same edge that enters WR.
  always_comb begin
    w_shift2 = w_opb - W_DW;
    w_alu    = '0;
    case (w_grp)
      G_ADD:  w_alu = mem_rdata + w_opb;
      G_NAND: w_alu = ~(mem_rdata & w_opb);
      G_SRL: begin
        // A shift amount of DATA_W or more turns into a left shift by (s - DATA_W).
        if (w_opb < W_DW) begin
          w_alu = mem_rdata >> w_opb;
        end else if (w_shift2 < W_DW) begin
          w_alu = mem_rdata << w_shift2;
        end else begin
          w_alu = '0;
        end
      end
      G_LT:    w_alu = {{(DATA_W-1){1'b0}}, (mem_rdata < w_opb)};
      G_MUL:   w_alu = mem_rdata * w_opb;
      default: w_alu = '0;
    endcase
  end

  // Branch target, resolved during the RDA read. For BZJ, rb holds M[B].
  // For BZJi, only the low ADDR_W bits of M[A]+B are needed.
  always_comb begin
    w_tgt = pc + A_ONE;
    if (w_imm) begin
      w_tgt = mem_rdata[ADDR_W-1:0] + w_b;
    end else if (r_rb == '0) begin
      w_tgt = mem_rdata[ADDR_W-1:0];
    end else begin
      w_tgt = pc + A_ONE;
    end
  end

  // Control FSM. It sequences the memory transactions and holds the
  // registered handshake outputs, the PC, the retire counter and the halt flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_iw      <= '0;
      r_rb      <= '0;
      r_ra      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      pc        <= '0;
      retired   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run && !halted) begin
            r_state  <= S_FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end
        S_FETCH: begin
          if (mem_rdy) begin
            r_iw <= mem_rdata[IW_W-1:0];
            if (!w_f_imm) begin
              r_state  <= S_RDB;
              mem_addr <= w_f_b;
            end else if (w_f_grp == G_CP) begin
              r_state   <= S_WR;
              mem_we    <= 1'b1;
              mem_addr  <= w_f_a;
              mem_wdata <= {{(DATA_W-ADDR_W){1'b0}}, w_f_b};
            end else begin
              r_state  <= S_RDA;
              mem_addr <= w_f_a;
            end
          end
        end
        S_RDB: begin
          if (mem_rdy) begin
            r_rb <= mem_rdata;
            if (w_grp == G_CPI && !w_imm) begin
              r_state  <= S_RDI;
              mem_addr <= mem_rdata[ADDR_W-1:0];
            end else if (w_grp == G_CPI) begin
              // CPIi: the destination is the pointer read earlier from M[A]
              r_state   <= S_WR;
              mem_we    <= 1'b1;
              mem_addr  <= r_ra;
              mem_wdata <= mem_rdata;
            end else if (w_grp == G_CP) begin
              r_state   <= S_WR;
              mem_we    <= 1'b1;
              mem_addr  <= w_a;
              mem_wdata <= mem_rdata;
            end else begin
              r_state  <= S_RDA;
              mem_addr <= w_a;
            end
          end
        end
        S_RDA: begin
          if (mem_rdy) begin
            r_ra <= mem_rdata[ADDR_W-1:0];
            if (w_grp == G_CPI) begin
              r_state  <= S_RDB;
              mem_addr <= w_b;
            end else if (w_grp == G_BZJ) begin
              mem_req <= 1'b0;
              pc      <= w_tgt;
              retired <= retired + RET_ONE;
              if (w_tgt == pc) begin
                r_state <= S_HALT;
                halted  <= 1'b1;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_state   <= S_WR;
              mem_we    <= 1'b1;
              mem_addr  <= w_a;
              mem_wdata <= w_alu;
            end
          end
        end
        S_RDI: begin
          if (mem_rdy) begin
            r_state   <= S_WR;
            mem_we    <= 1'b1;
            mem_addr  <= w_a;
            mem_wdata <= mem_rdata;
          end
        end
        S_WR: begin
          if (mem_rdy) begin
            r_state <= S_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            pc      <= pc + A_ONE;
            retired <= retired + RET_ONE;
          end
        end
        S_HALT: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          halted  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vscpu_mem_hs.sv
// Testbench for vscpu_mem_hs. A memory model with programmable wait states
// services the main instance (ADDR_W=14, DATA_W=32). Every expected memory
// write goes into a scoreboard queue. A monitor thread pops an entry for each
// write the DUT completes and compares it. A second instance with ADDR_W=10
// and DATA_W=24 runs the ADD program.
module tb_vscpu_mem_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        mem_req;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rdy;
  logic        halted;
  logic [13:0] pc;
  logic [15:0] retired;

  logic        run2;
  logic        mem2_req;
  logic        mem2_we;
  logic [9:0]  mem2_addr;
  logic [23:0] mem2_wdata;
  logic [23:0] mem2_rdata;
  logic        halted2;
  logic [9:0]  pc2;
  logic [15:0] retired2;

  logic [31:0] mem  [0:16383];
  logic [23:0] mem2 [0:1023];
  int          wcnt;
  int          wait_n;
  logic        hold_wr;
  int          cyc;
  int          start_cyc;
  int          n_checks;
  int          n_err;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  assign mem_rdata  = mem[mem_addr];
  assign mem2_rdata = mem2[mem2_addr];
  assign mem_rdy    = (hold_wr && mem_we) ? 1'b0 : (wcnt >= wait_n);

  vscpu_mem_hs #(.ADDR_W(14), .DATA_W(32), .RET_W(16)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .halted(halted), .pc(pc), .retired(retired)
  );

  vscpu_mem_hs #(.ADDR_W(10), .DATA_W(24), .RET_W(16)) dut2 (
    .clk(clk), .rst(rst), .run(run2),
    .mem_req(mem2_req), .mem_we(mem2_we), .mem_addr(mem2_addr),
    .mem_wdata(mem2_wdata), .mem_rdata(mem2_rdata), .mem_rdy(1'b1),
    .halted(halted2), .pc(pc2), .retired(retired2)
  );

  function automatic logic [31:0] enc(input logic [3:0] op, input int a, input int b);
    return {op, a[13:0], b[13:0]};
  endfunction

  function automatic logic [23:0] enc2(input logic [3:0] op, input int a, input int b);
    return {op, a[9:0], b[9:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input int a, input logic [31:0] d, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  // Memory model: completes transactions, counts wait states, tracks cycles.
  task automatic mem_proc();
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
      if (mem_req && mem_rdy) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        wcnt <= 0;
      end else if (mem_req) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
      end
      if (mem2_req && mem2_we) mem2[mem2_addr] <= mem2_wdata;
    end
  endtask

  // Monitor: handshake stability through wait states, and scoreboard pops on writes.
  task automatic monitor();
    exp_t        e;
    logic        p_wait;
    logic [13:0] p_addr;
    logic        p_we;
    logic [31:0] p_wd;
    p_wait = 1'b0;
    p_addr = '0;
    p_we   = 1'b0;
    p_wd   = '0;
    forever begin
      @(negedge clk);
      if (rst && p_wait) begin
        chk("hold_req", 64'(mem_req), 64'(1));
        chk("hold_addr", 64'(mem_addr), 64'(p_addr));
        chk("hold_we", 64'(mem_we), 64'(p_we));
        chk("hold_wdata", 64'(mem_wdata), 64'(p_wd));
      end
      if (rst && mem_req && mem_we && mem_rdy) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_wdata);
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(e.addr));
          chk("wr_data", 64'(mem_wdata), 64'(e.data));
          if (e.cyc >= 0) chk("wr_cycle", 64'(cyc + 1 - start_cyc), 64'(e.cyc));
        end
      end
      p_wait = rst && mem_req && !mem_rdy;
      p_addr = mem_addr;
      p_we   = mem_we;
      p_wd   = mem_wdata;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst     = 1'b0;
    run     = 1'b0;
    run2    = 1'b0;
    wait_n  = 0;
    hold_wr = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    for (int i = 0; i < 1024; i++) mem2[i] = 24'h0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req", 64'(mem_req), 64'(0));
    chk("rst_we", 64'(mem_we), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    chk("rst_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_halted", 64'(halted), 64'(0));
    chk("rst_pc", 64'(pc), 64'(0));
    chk("rst_retired", 64'(retired), 64'(0));
  endtask

  task automatic start_run();
    @(negedge clk);
    #2;
    start_cyc = cyc;
    run = 1'b1;
  endtask

  task automatic wait_halt(input string name, input int bound);
    int i;
    i = 0;
    while (!halted && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_halted"}, 64'(halted), 64'(1));
    chk({name, "_sb_empty"}, 64'(sb_q.size()), 64'(0));
  endtask

  initial begin
    int   i;
    logic seen;
    int   ret_snap;
    rst = 1'b0; run = 1'b0; run2 = 1'b0; wait_n = 0; hold_wr = 1'b0;
    wcnt = 0; cyc = 0; start_cyc = 0; n_checks = 0; n_err = 0;
    fork
      mem_proc();
      monitor();
    join_none

    // ADD with rdy tied high; the second instance runs the same program
    do_reset();
    mem[0] = enc(4'h0, 10, 11); mem[10] = 32'd5; mem[11] = 32'd7;
    mem[1] = enc(4'hD, 100, 1);
    mem2[0] = enc2(4'h0, 10, 11); mem2[10] = 24'd5; mem2[11] = 24'd7;
    mem2[1] = enc2(4'hD, 100, 1);
    exp_wr(10, 32'd12, 5);
    run2 = 1'b1;
    start_run();
    i = 0;
    while (retired != 16'd1 && i < 50) begin @(negedge clk); i++; end
    chk("add_retired", 64'(retired), 64'(1));
    chk("add_pc", 64'(pc), 64'(1));
    wait_halt("add", 100);
    chk("add_final_pc", 64'(pc), 64'(1));
    chk("add_final_ret", 64'(retired), 64'(2));
    @(negedge clk);
    chk("w24_halted", 64'(halted2), 64'(1));
    chk("w24_pc", 64'(pc2), 64'(1));
    chk("w24_retired", 64'(retired2), 64'(2));
    chk("w24_m10", 64'(mem2[10]), 64'(24'd12));

    // CPi with three wait states per transaction
    do_reset();
    wait_n = 3;
    mem[0] = enc(4'h9, 20, 16'h3FFF);
    mem[1] = enc(4'hD, 100, 1);
    exp_wr(20, 32'd16383, 9);
    start_run();
    wait_halt("waits", 200);

    // CPIi then CPI, one wait state each
    do_reset();
    wait_n = 1;
    mem[30] = 32'd40; mem[31] = 32'hDEAD;
    mem[0] = enc(4'hB, 30, 31);
    mem[1] = enc(4'hA, 50, 30);
    mem[2] = enc(4'hD, 100, 2);
    exp_wr(40, 32'hDEAD, -1);
    exp_wr(50, 32'hDEAD, -1);
    start_run();
    wait_halt("cpi", 200);
    chk("cpi_retired", 64'(retired), 64'(3));

    // SRL boundaries and the remaining ALU/copy ops
    do_reset();
    mem[60] = 32'h80000001; mem[61] = 32'h80000001; mem[62] = 32'h80000001;
    mem[63] = 32'h000000F0; mem[64] = 32'd4;
    mem[65] = 32'hFF00FF00; mem[66] = 32'h0FF00FF0;
    mem[67] = 32'd3; mem[68] = 32'd9; mem[69] = 32'd9;
    mem[70] = 32'h00010001; mem[71] = 32'h00010001;
    mem[72] = 32'hFFFFFFFF; mem[73] = 32'hFFFFFFFF; mem[74] = 32'hFFFFFFFF;
    mem[76] = 32'h12345678;
    mem[0]  = enc(4'h5, 60, 1);      exp_wr(60, 32'h40000000, -1);
    mem[1]  = enc(4'h5, 61, 33);     exp_wr(61, 32'h00000002, -1);
    mem[2]  = enc(4'h5, 62, 64);     exp_wr(62, 32'h00000000, -1);
    mem[3]  = enc(4'h4, 63, 64);     exp_wr(63, 32'h0000000F, -1);
    mem[4]  = enc(4'h2, 65, 66);     exp_wr(65, 32'hF0FFF0FF, -1);
    mem[5]  = enc(4'h7, 67, 5);      exp_wr(67, 32'h00000001, -1);
    mem[6]  = enc(4'h6, 68, 69);     exp_wr(68, 32'h00000000, -1);
    mem[7]  = enc(4'hE, 70, 71);     exp_wr(70, 32'h00020001, -1);
    mem[8]  = enc(4'hF, 72, 3);      exp_wr(72, 32'hFFFFFFFD, -1);
    mem[9]  = enc(4'h1, 73, 16'h3FFF); exp_wr(73, 32'h00003FFE, -1);
    mem[10] = enc(4'h3, 74, 16'h00F0); exp_wr(74, 32'hFFFFFF0F, -1);
    mem[11] = enc(4'h8, 75, 76);     exp_wr(75, 32'h12345678, -1);
    mem[12] = enc(4'hD, 100, 12);
    start_run();
    wait_halt("alu", 400);
    chk("alu_pc", 64'(pc), 64'(12));
    chk("alu_retired", 64'(retired), 64'(13));

    // Branches and halt; after HALT there must be no requests and retired must not move
    do_reset();
    mem[81] = 32'd3; mem[82] = 32'd7; mem[83] = 32'd0;
    mem[0] = enc(4'hC, 80, 81);
    mem[1] = enc(4'hC, 82, 83);
    mem[7] = enc(4'h1, 90, 1);       exp_wr(90, 32'd1, -1);
    mem[8] = enc(4'h9, 91, 4);       exp_wr(91, 32'd4, -1);
    mem[9] = enc(4'hD, 91, 5);
    start_run();
    wait_halt("br", 200);
    chk("br_pc", 64'(pc), 64'(9));
    chk("br_retired", 64'(retired), 64'(5));
    ret_snap = int'(retired);
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (mem_req) seen = 1'b1; end
    chk("halt_no_req", 64'(seen), 64'(0));
    chk("halt_ret_frozen", 64'(retired), 64'(ret_snap));
    chk("halt_sticky", 64'(halted), 64'(1));

    // PC wrap from 0x3FFF to 0; a truncated BZJi target of 0 then halts
    do_reset();
    mem[0]     = enc(4'hD, 100, 16'h3FFF);
    mem[16383] = enc(4'h9, 100, 1);
    exp_wr(100, 32'd1, -1);
    start_run();
    wait_halt("wrap", 200);
    chk("wrap_pc", 64'(pc), 64'(0));
    chk("wrap_retired", 64'(retired), 64'(3));

    // run=0 idles; reset during a stalled write aborts the write
    do_reset();
    mem[0] = enc(4'h9, 95, 16'h55); mem[95] = 32'h777;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (mem_req) seen = 1'b1; end
    chk("run0_no_req", 64'(seen), 64'(0));
    hold_wr = 1'b1;
    start_run();
    i = 0;
    while (!(mem_req && mem_we) && i < 20) begin @(negedge clk); i++; end
    chk("wr_stall_reached", 64'(mem_req && mem_we), 64'(1));
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_req", 64'(mem_req), 64'(0));
    chk("abort_we", 64'(mem_we), 64'(0));
    repeat (3) @(negedge clk);
    chk("abort_mem", 64'(mem[95]), 64'(32'h777));
    chk("abort_sb_empty", 64'(sb_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
